// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write arbiter.
package rf_pkg;

    localparam int DW       = 8;
    localparam int AW       = 4;
    localparam int NUM_REGS = 16;
    localparam int MAX_WAIT = 3;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } rf_arb_state_t;

    // One register-file write: enable, destination and data travel together.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] dest;
        logic [DW-1:0] wdata;
    } rf_wr_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Handshake and register-file write bundle for rf_write_arbiter.
// The master side drives requests and observes grants and the write port;
// the slave side is the arbiter itself.
interface rf_write_arbiter_if #(
    parameter int DW = rf_pkg::DW,
    parameter int AW = rf_pkg::AW
);
    import rf_pkg::*;

    logic          clr_start;
    logic          clr_busy;

    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_dest;
    logic [DW-1:0] alu_data;

    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_dest;
    logic [DW-1:0] ld_data;

    logic          rf_we;
    logic [AW-1:0] rf_dest;
    logic [DW-1:0] rf_wdata;

    modport master (
        output clr_start,
        output alu_valid, alu_dest, alu_data,
        output ld_valid, ld_dest, ld_data,
        input  clr_busy, alu_ready, ld_ready,
        input  rf_we, rf_dest, rf_wdata
    );

    modport slave (
        input  clr_start,
        input  alu_valid, alu_dest, alu_data,
        input  ld_valid, ld_dest, ld_data,
        output clr_busy, alu_ready, ld_ready,
        output rf_we, rf_dest, rf_wdata
    );

endinterface

// File: rtl/rf_clear_seq.sv
// Address generator for the register-file clear sequence: walks 0..NUM_REGS-1
// one step per advance and flags the final address.
module rf_clear_seq #(
    parameter int AW       = rf_pkg::AW,
    parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    input  logic          advance,
    output logic [AW-1:0] addr,
    output logic          last
);
    import rf_pkg::*;

    logic [AW-1:0] addr_q;

    assign addr = addr_q;
    assign last = (addr_q == AW'(NUM_REGS - 1));

    // Address counter; wraps to 0 after the last register so the next clear starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (restart) begin
            addr_q <= '0;
        end else if (advance) begin
            addr_q <= last ? '0 : addr_q + 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between ALU writeback and
// memory-load writeback, and runs a full clear after reset or on command.
// Load normally wins; an ALU request stalled MAX_WAIT cycles is forced through.
module rf_write_arbiter #(
    parameter int DW       = rf_pkg::DW,
    parameter int AW       = rf_pkg::AW,
    parameter int NUM_REGS = rf_pkg::NUM_REGS,
    parameter int MAX_WAIT = rf_pkg::MAX_WAIT
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_write_arbiter_if.slave  bus
);
    import rf_pkg::*;

    localparam int WW = $clog2(MAX_WAIT + 1);

    rf_arb_state_t state_q;
    rf_arb_state_t state_d;

    logic [WW-1:0] wait_q;
    logic          at_max;

    logic          clr_busy;
    logic          alu_ready;
    logic          ld_ready;
    logic          clr_adv;
    logic          clr_restart;
    logic [AW-1:0] clr_addr;
    logic          clr_last;

    logic          alu_grant;
    logic          ld_grant;

    rf_wr_t        wr_p0;
    rf_wr_t        wr_p1;

    rf_clear_seq #(
        .AW       (AW),
        .NUM_REGS (NUM_REGS)
    ) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (clr_restart),
        .advance (clr_adv),
        .addr    (clr_addr),
        .last    (clr_last)
    );

    assign at_max    = (wait_q == WW'(MAX_WAIT));
    assign alu_grant = bus.alu_valid & alu_ready;
    assign ld_grant  = bus.ld_valid & ld_ready;

    // State register; reset always re-enters the clear sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave clear once the last address is issued; clr_start only matters in run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clr_last)      state_d = S_RUN;
            S_RUN:   if (bus.clr_start) state_d = S_CLEAR;
            default:                    state_d = S_CLEAR;
        endcase
    end

    // Outputs: ready signals come straight from arbitration; a clear command blocks every grant.
    always_comb begin
        clr_busy    = 1'b0;
        alu_ready   = 1'b0;
        ld_ready    = 1'b0;
        clr_adv     = 1'b0;
        clr_restart = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_busy = 1'b1;
                clr_adv  = 1'b1;
            end
            S_RUN: begin
                if (bus.clr_start) begin
                    clr_restart = 1'b1;
                end else begin
                    alu_ready = at_max | ~bus.ld_valid;
                    ld_ready  = ~at_max;
                end
            end
            default: begin
                clr_busy = 1'b1;
            end
        endcase
    end

    // Starvation counter for a pending ALU request; saturates at MAX_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (state_q == S_CLEAR || clr_restart) begin
            wait_q <= '0;
        end else if (!bus.alu_valid || alu_grant) begin
            wait_q <= '0;
        end else if (!at_max) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    // Write selection: clear writes zero; otherwise the single granted request, else idle with dest/data held.
    always_comb begin
        wr_p0    = wr_p1;
        wr_p0.we = 1'b0;
        if (state_q == S_CLEAR) begin
            wr_p0.we    = 1'b1;
            wr_p0.dest  = clr_addr;
            wr_p0.wdata = '0;
        end else if (ld_grant) begin
            wr_p0.we    = 1'b1;
            wr_p0.dest  = bus.ld_dest;
            wr_p0.wdata = bus.ld_data;
        end else if (alu_grant) begin
            wr_p0.we    = 1'b1;
            wr_p0.dest  = bus.alu_dest;
            wr_p0.wdata = bus.alu_data;
        end
    end

    // ---- stage p0 -> p1: registered write port feeding the register file ----
    // Output register; a grant in cycle N is presented to the register file in cycle N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_p1 <= '0;
        end else begin
            wr_p1 <= wr_p0;
        end
    end

    assign bus.clr_busy  = clr_busy;
    assign bus.alu_ready = alu_ready;
    assign bus.ld_ready  = ld_ready;
    assign bus.rf_we     = wr_p1.we;
    assign bus.rf_dest   = wr_p1.dest;
    assign bus.rf_wdata  = wr_p1.wdata;

endmodule
